// File: rtl/peripheral_bus_pkg.sv
// Shared types and widths for the peripheral bus bridge.
// Imported by the bridge, its decoder and the register interface.
package peripheral_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } bridge_state_t;

  localparam int DATA_WIDTH = 32;
  localparam int DEF_BUS_ADDR_WIDTH = 8;

endpackage

// File: rtl/peripheral_register_interface.sv
// Register-file side of the bridge: one-hot write strobes,
// shared write data and per-register read data.
interface peripheral_register_interface #(
  parameter int REGS = 3
);
  import peripheral_bus_pkg::*;

  logic [REGS-1:0]       write_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out [REGS];

  modport driver (
    output write_en,
    output data_in,
    input  data_out
  );

  modport peripheral (
    input  write_en,
    input  data_in,
    output data_out
  );

endinterface

// File: rtl/peripheral_bus_decode.sv
// Full-width address decode: one-hot write strobe plus range flag.
// Upper address bits never alias onto a register.
module peripheral_bus_decode
  import peripheral_bus_pkg::*;
#(
  parameter int REGS           = 3,
  parameter int BUS_ADDR_WIDTH = DEF_BUS_ADDR_WIDTH
) (
  input  logic [BUS_ADDR_WIDTH-1:0] addr,
  input  logic                      enable,
  output logic [REGS-1:0]           write_en,
  output logic                      in_range
);

  logic hit;

  always_comb begin
    write_en = '0;
    in_range = 1'b0;
    hit      = 1'b0;
    for (int i = 0; i < REGS; i++) begin
      hit         = (addr == BUS_ADDR_WIDTH'(i));
      write_en[i] = enable & hit;
      in_range    = in_range | hit;
    end
  end

endmodule

// File: rtl/peripheral_bus_bridge.sv
// Valid/ready bus to register-file bridge: one request at a time,
// IDLE -> ACCESS -> RESP with a held response.
module peripheral_bus_bridge
  import peripheral_bus_pkg::*;
#(
  parameter int REGS           = 3,
  parameter int BUS_ADDR_WIDTH = DEF_BUS_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [BUS_ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [DATA_WIDTH-1:0]     resp_rdata,
  output logic                      resp_error,
  peripheral_register_interface.driver reg_io
);

  bridge_state_t state;

  logic                      write_q;
  logic [BUS_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [REGS-1:0]           dec_we;
  logic                      in_range;
  logic                      in_access;
  logic [DATA_WIDTH-1:0]     rd_mux;

  assign in_access = (state == ACCESS);

  peripheral_bus_decode #(
    .REGS           (REGS),
    .BUS_ADDR_WIDTH (BUS_ADDR_WIDTH)
  ) u_decode (
    .addr     (addr_q),
    .enable   (in_access & write_q),
    .write_en (dec_we),
    .in_range (in_range)
  );

  // Strobes come straight from registered state, so reset kills them at once.
  assign reg_io.write_en = dec_we;
  assign reg_io.data_in  = in_access ? wdata_q : '0;

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < REGS; i++) begin
      if (addr_q == BUS_ADDR_WIDTH'(i)) rd_mux = reg_io.data_out[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            state     <= ACCESS;
            req_ready <= 1'b0;
            write_q   <= req_write;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
          end
        end
        ACCESS: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_error <= ~in_range;
          resp_rdata <= (in_range && !write_q) ? rd_mux : '0;
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
